// File: rtl/axi_gpio_irq_if.sv
// AXI4 slave-side signal bundle for the GPIO controller (single-beat transfers only).
//
// Handshake rule for every channel: a beat transfers on a rising clk edge where
// both valid and ready are high. The source keeps valid and its payload stable
// until that edge. The sink may raise or drop ready at any time.
interface axi_gpio_irq_if #(
    parameter int ID_WIDTH = 4
);
    logic                awvalid;
    logic                awready;
    logic [31:0]         awaddr;
    logic [ID_WIDTH-1:0] awid;

    logic                wvalid;
    logic                wready;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;

    logic                bvalid;
    logic                bready;
    logic [1:0]          bresp;
    logic [ID_WIDTH-1:0] bid;

    logic                arvalid;
    logic                arready;
    logic [31:0]         araddr;
    logic [ID_WIDTH-1:0] arid;

    logic                rvalid;
    logic                rready;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic [ID_WIDTH-1:0] rid;
    logic                rlast;

    modport slave (
        input  awvalid, awaddr, awid,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready
    );

    modport master (
        output awvalid, awaddr, awid,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready
    );
endinterface

// File: rtl/axi_gpio_irq.sv
// AXI slave GPIO controller: per-pin direction, atomic set/clear, synchronised
// inputs and rising/falling edge interrupts merged into one registered IRQ level.
module axi_gpio_irq #(
    parameter int          GPIO_WIDTH  = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'hD000_0000,
    parameter int          ID_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    axi_gpio_irq_if.slave         bus,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe_o,
    output logic                  irq_o,
    output logic                  wr_fsm_state,
    output logic                  rd_fsm_state
);

    localparam logic [7:0] OFF_OUT     = 8'h00;
    localparam logic [7:0] OFF_DIR     = 8'h04;
    localparam logic [7:0] OFF_IN      = 8'h08;
    localparam logic [7:0] OFF_RISE_EN = 8'h0C;
    localparam logic [7:0] OFF_FALL_EN = 8'h10;
    localparam logic [7:0] OFF_STATUS  = 8'h14;
    localparam logic [7:0] OFF_SET     = 8'h18;
    localparam logic [7:0] OFF_CLR     = 8'h1C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

    // Only the low address byte is decoded; the base is resolved by the interconnect.
    logic unused_bits;
    assign unused_bits = ^{bus.awaddr[31:8], bus.araddr[31:8], BASE_ADDR};

    // ---------------- register state ----------------
    logic [GPIO_WIDTH-1:0] out_q;
    logic [GPIO_WIDTH-1:0] dir_q;
    logic [GPIO_WIDTH-1:0] rise_en_q;
    logic [GPIO_WIDTH-1:0] fall_en_q;
    logic [GPIO_WIDTH-1:0] status_q;
    logic [GPIO_WIDTH-1:0] in_prev_q;
    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] in_sync;
    logic                  irq_q;

    // ---------------- write channel state ----------------
    wr_state_t             wstate;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [7:0]            aw_off_q;
    logic [ID_WIDTH-1:0]   aw_id_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;

    // ---------------- read channel state ----------------
    rd_state_t             rstate;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [31:0]           rdata_q;
    logic [1:0]            rresp_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic                  rlast_q;

    // ---------------- write decode ----------------
    logic                  aw_hit;
    logic                  w_hit;
    logic                  wr_fire;
    logic [7:0]            wr_off;
    logic [ID_WIDTH-1:0]   wr_id;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic                  wr_ok;
    logic [31:0]           strb_mask;
    logic [GPIO_WIDTH-1:0] wm;
    logic [GPIO_WIDTH-1:0] wd;
    logic [GPIO_WIDTH-1:0] w1c_mask;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] fall;

    assign aw_hit = bus.awvalid & awready_q;
    assign w_hit  = bus.wvalid & wready_q;

    // A low ready while idle means that half of the transaction is already held.
    assign wr_fire = (wstate == W_IDLE) & (aw_hit | ~awready_q) & (w_hit | ~wready_q);

    // Same-cycle captures bypass the holding registers.
    assign wr_off  = aw_hit ? bus.awaddr[7:0] : aw_off_q;
    assign wr_id   = aw_hit ? bus.awid        : aw_id_q;
    assign wr_data = w_hit  ? bus.wdata       : wdata_q;
    assign wr_strb = w_hit  ? bus.wstrb       : wstrb_q;

    // Byte-lane mask and write decode; IN is read-only so it is an error target.
    always_comb begin
        strb_mask = '0;
        for (int i = 0; i < 32; i++) begin
            strb_mask[i] = wr_strb[i/8];
        end
        unique case (wr_off)
            OFF_OUT, OFF_DIR, OFF_RISE_EN, OFF_FALL_EN,
            OFF_STATUS, OFF_SET, OFF_CLR: wr_ok = 1'b1;
            default:                      wr_ok = 1'b0;
        endcase
    end

    assign wm = strb_mask[GPIO_WIDTH-1:0];
    assign wd = wr_data[GPIO_WIDTH-1:0] & wm;

    assign w1c_mask = (wr_fire && wr_ok && wr_off == OFF_STATUS) ? wd : '0;

    // ---------------- input synchroniser and edge detect ----------------
    assign in_sync = sync_q[SYNC_STAGES-1];
    assign rise    = in_sync & ~in_prev_q & rise_en_q;
    assign fall    = ~in_sync & in_prev_q & fall_en_q;

    // Pad inputs pass through a SYNC_STAGES-deep flop chain, then one more for edge history.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            in_prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            in_prev_q <= in_sync;
        end
    end

    // Write FSM: collects AW and W in either order, commits, then holds B until accepted.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wstate    <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            aw_off_q  <= '0;
            aw_id_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (aw_hit) begin
                        aw_off_q  <= bus.awaddr[7:0];
                        aw_id_q   <= bus.awid;
                        awready_q <= 1'b0;
                    end
                    if (w_hit) begin
                        wdata_q  <= bus.wdata;
                        wstrb_q  <= bus.wstrb;
                        wready_q <= 1'b0;
                    end
                    if (wr_fire) begin
                        wstate   <= W_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        bid_q    <= wr_id;
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        wstate    <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Register file: commits the write on the fire edge; status collects edges every cycle.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
        end else begin
            if (wr_fire && wr_ok) begin
                unique case (wr_off)
                    OFF_OUT:     out_q     <= (out_q & ~wm) | wd;
                    OFF_DIR:     dir_q     <= (dir_q & ~wm) | wd;
                    OFF_RISE_EN: rise_en_q <= (rise_en_q & ~wm) | wd;
                    OFF_FALL_EN: fall_en_q <= (fall_en_q & ~wm) | wd;
                    OFF_SET:     out_q     <= out_q | wd;
                    OFF_CLR:     out_q     <= out_q & ~wd;
                    default:     ;
                endcase
            end
            // A fresh edge outranks a simultaneous clear of the same bit.
            status_q <= (status_q & ~w1c_mask) | rise | fall;
        end
    end

    // Interrupt line is the registered OR of all pending status bits.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |status_q;
        end
    end

    // ---------------- read decode ----------------
    logic [31:0] rd_val;
    logic        rd_ok;

    // Read mux over pre-edge register values, zero-extended to the bus width.
    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b1;
        unique case (bus.araddr[7:0])
            OFF_OUT:          rd_val[GPIO_WIDTH-1:0] = out_q;
            OFF_DIR:          rd_val[GPIO_WIDTH-1:0] = dir_q;
            OFF_IN:           rd_val[GPIO_WIDTH-1:0] = in_sync;
            OFF_RISE_EN:      rd_val[GPIO_WIDTH-1:0] = rise_en_q;
            OFF_FALL_EN:      rd_val[GPIO_WIDTH-1:0] = fall_en_q;
            OFF_STATUS:       rd_val[GPIO_WIDTH-1:0] = status_q;
            OFF_SET, OFF_CLR: rd_val = '0;
            default:          rd_ok  = 1'b0;
        endcase
    end

    // Read FSM: capture address and data together, hold R until accepted.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            rstate    <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rlast_q   <= 1'b0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (bus.arvalid) begin
                        rstate    <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= 1'b1;
                        rdata_q   <= rd_val;
                        rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        rid_q     <= bus.arid;
                    end
                end
                R_DATA: begin
                    if (bus.rready) begin
                        rstate    <= R_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.bid     = bid_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rid     = rid_q;
    assign bus.rlast   = rlast_q;

    assign gpio_o       = out_q;
    assign gpio_oe_o    = dir_q;
    assign irq_o        = irq_q;
    assign wr_fsm_state = wstate;
    assign rd_fsm_state = rstate;

endmodule
